rob_multi: RTL

- Parametrised reorder buffer; successor to the 16-entry single-commit ROB.
- Sits between issue, the ALU/SLB writeback paths, the register file and pc_reg.
- Adds the following over the previous ROB:
  - all DEPTH entries usable, tracked by an occupancy counter;
  - per-entry valid bits, so stale writebacks after a flush are dropped;
  - branch prediction stored in the branch's own entry;
  - optional dual commit.

---
 rtl/rob_multi_pkg.sv | 12 +
 rtl/rob_commit_sel.sv | 49 ++++
 rtl/rob_multi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_pkg.sv
// Shared encodings for the multi-commit reorder buffer: entry types and boolean constants.
package rob_multi_pkg;

  localparam logic [1:0] T_OTHER  = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_JALR   = 2'd3;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational retire decision for the two commit slots, the commit-0 pulse and mispredict flush.
module rob_commit_sel
  import rob_multi_pkg::*;
#(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned COMMIT2 = 1
) (
  input  logic [IDX_W:0] count,
  input  logic           head_valid,
  input  logic           head_ready,
  input  logic [1:0]     head_type,
  input  logic           head_taken,
  input  logic           head_pred,
  input  logic           next_valid,
  input  logic           next_ready,
  input  logic [1:0]     next_type,
  output logic           commit0_c,
  output logic           commit1_c,
  output logic           cm0_pulse_c,
  output logic           flush_c,
  output logic [1:0]     ncommit_c
);

  always_comb begin
    commit0_c   = FALSE;
    commit1_c   = FALSE;
    cm0_pulse_c = FALSE;
    flush_c     = FALSE;
    if (count != '0 && head_valid && head_ready) begin
      commit0_c = TRUE;
      case (head_type)
        T_OTHER:  cm0_pulse_c = TRUE;
        T_JALR: begin
          cm0_pulse_c = TRUE;
          flush_c     = TRUE;
        end
        T_BRANCH: flush_c = (head_taken != head_pred);
        default:  cm0_pulse_c = FALSE;
      endcase
      // Control-flow entries never pair; only OTHER/STORE followed by OTHER retires two-wide.
      if (COMMIT2 != 0 && count >= (IDX_W+1)'(2) && next_valid && next_ready &&
          (head_type == T_OTHER || head_type == T_STORE) && next_type == T_OTHER)
        commit1_c = TRUE;
    end
  end

  assign ncommit_c = 2'(commit0_c) + 2'(commit1_c);

endmodule

// File: rtl/rob_multi.sv
// Parametrised reorder buffer with per-entry valid bits, in-entry branch prediction and optional dual commit.
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned COMMIT2 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              issue_valid,
  input  logic [1:0]        issue_type,
  input  logic [REG_W-1:0]  issue_dest,
  input  logic              issue_pred_taken,
  output logic              issue_ready,
  output logic [IDX_W-1:0]  issue_idx,
  input  logic [IDX_W-1:0]  rs1_idx,
  input  logic [IDX_W-1:0]  rs2_idx,
  output logic              rs1_ready,
  output logic              rs2_ready,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb0_valid,
  input  logic [IDX_W-1:0]  wb0_idx,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb0_taken,
  input  logic [DATA_W-1:0] wb0_target,
  input  logic              wb1_valid,
  input  logic [IDX_W-1:0]  wb1_idx,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              cdb0_valid,
  output logic [IDX_W-1:0]  cdb0_idx,
  output logic [DATA_W-1:0] cdb0_data,
  output logic              cdb1_valid,
  output logic [IDX_W-1:0]  cdb1_idx,
  output logic [DATA_W-1:0] cdb1_data,
  output logic              store_at_head,
  output logic              cm0_valid,
  output logic [REG_W-1:0]  cm0_reg,
  output logic [DATA_W-1:0] cm0_data,
  output logic [IDX_W-1:0]  cm0_idx,
  output logic              cm1_valid,
  output logic [REG_W-1:0]  cm1_reg,
  output logic [DATA_W-1:0] cm1_data,
  output logic [IDX_W-1:0]  cm1_idx,
  output logic              flush,
  output logic [DATA_W-1:0] flush_pc
);

  logic [IDX_W-1:0]  head_q, tail_q, head_nxt;
  logic [IDX_W:0]    count_q;
  logic [DEPTH-1:0]  valid_q, ready_q, pred_q, taken_q;
  logic [1:0]        type_q   [DEPTH];
  logic [REG_W-1:0]  dest_q   [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] target_q [DEPTH];

  logic       issue_fire, wb0_hit, wb1_hit;
  logic       commit0_c, commit1_c, cm0_pulse_c, flush_c;
  logic [1:0] ncommit_c;

  assign head_nxt      = head_q + IDX_W'(1);
  assign issue_ready   = (count_q != (IDX_W+1)'(DEPTH));
  assign issue_idx     = tail_q;
  assign issue_fire    = issue_valid && issue_ready && !flush;
  assign store_at_head = valid_q[head_q] && (type_q[head_q] == T_STORE);

  // Writebacks to entries cleared by a flush (or colliding with one) are dropped.
  assign wb0_hit = wb0_valid && valid_q[wb0_idx] && !flush_c;
  assign wb1_hit = wb1_valid && valid_q[wb1_idx] && !flush_c;

  assign rs1_ready = ready_q[rs1_idx];
  assign rs2_ready = ready_q[rs2_idx];
  assign rs1_data  = data_q[rs1_idx];
  assign rs2_data  = data_q[rs2_idx];

  rob_commit_sel #(
    .IDX_W   (IDX_W),
    .COMMIT2 (COMMIT2)
  ) u_commit_sel (
    .count       (count_q),
    .head_valid  (valid_q[head_q]),
    .head_ready  (ready_q[head_q]),
    .head_type   (type_q[head_q]),
    .head_taken  (taken_q[head_q]),
    .head_pred   (pred_q[head_q]),
    .next_valid  (valid_q[head_nxt]),
    .next_ready  (ready_q[head_nxt]),
    .next_type   (type_q[head_nxt]),
    .commit0_c   (commit0_c),
    .commit1_c   (commit1_c),
    .cm0_pulse_c (cm0_pulse_c),
    .flush_c     (flush_c),
    .ncommit_c   (ncommit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
      pred_q  <= '0;
      taken_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        type_q[i]   <= T_OTHER;
        dest_q[i]   <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
      cdb0_valid <= FALSE;
      cdb0_idx   <= '0;
      cdb0_data  <= '0;
      cdb1_valid <= FALSE;
      cdb1_idx   <= '0;
      cdb1_data  <= '0;
      cm0_valid  <= FALSE;
      cm0_reg    <= '0;
      cm0_data   <= '0;
      cm0_idx    <= '0;
      cm1_valid  <= FALSE;
      cm1_reg    <= '0;
      cm1_data   <= '0;
      cm1_idx    <= '0;
      flush      <= FALSE;
      flush_pc   <= '0;
    end else if (rdy) begin
      cdb0_valid <= FALSE;
      cdb1_valid <= FALSE;
      cm0_valid  <= FALSE;
      cm1_valid  <= FALSE;
      flush      <= FALSE;

      if (wb0_hit) begin
        ready_q[wb0_idx] <= TRUE;
        case (type_q[wb0_idx])
          T_OTHER, T_JALR: begin
            data_q[wb0_idx] <= wb0_data;
            if (type_q[wb0_idx] == T_JALR) target_q[wb0_idx] <= wb0_target;
            cdb0_valid <= TRUE;
            cdb0_idx   <= wb0_idx;
            cdb0_data  <= wb0_data;
          end
          T_BRANCH: begin
            taken_q[wb0_idx]  <= wb0_taken;
            target_q[wb0_idx] <= wb0_target;
          end
          default: ;
        endcase
      end

      if (wb1_hit) begin
        ready_q[wb1_idx] <= TRUE;
        if (type_q[wb1_idx] == T_OTHER || type_q[wb1_idx] == T_JALR) begin
          data_q[wb1_idx] <= wb1_data;
          cdb1_valid <= TRUE;
          cdb1_idx   <= wb1_idx;
          cdb1_data  <= wb1_data;
        end
      end

      if (commit0_c) valid_q[head_q] <= FALSE;
      if (commit1_c) valid_q[head_nxt] <= FALSE;

      if (cm0_pulse_c) begin
        cm0_valid <= TRUE;
        cm0_reg   <= dest_q[head_q];
        cm0_data  <= data_q[head_q];
        cm0_idx   <= head_q;
      end
      if (commit1_c) begin
        cm1_valid <= TRUE;
        cm1_reg   <= dest_q[head_nxt];
        cm1_data  <= data_q[head_nxt];
        cm1_idx   <= head_nxt;
      end

      head_q <= head_q + IDX_W'(ncommit_c);

      // A flushing commit is always single-wide, so the new head is head+1.
      if (flush_c) begin
        valid_q  <= '0;
        tail_q   <= head_nxt;
        count_q  <= '0;
        flush    <= TRUE;
        flush_pc <= target_q[head_q];
      end else begin
        if (issue_fire) begin
          valid_q[tail_q] <= TRUE;
          ready_q[tail_q] <= FALSE;
          type_q[tail_q]  <= issue_type;
          dest_q[tail_q]  <= issue_dest;
          pred_q[tail_q]  <= issue_pred_taken;
          tail_q          <= tail_q + IDX_W'(1);
        end
        count_q <= count_q + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(ncommit_c);
      end
    end
  end

endmodule
